// File: rtl/nerv_mem_arbiter_pkg.sv
// Shared types for the nerv instruction/data memory arbiter.
// Holds the FSM encoding and the captured data request bundle.
package nerv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DREQ,
    IREQ,
    IRSP
  } state_t;

  localparam logic [31:0] NERV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mreq_t;

endpackage

// File: rtl/nerv_mem_arbiter_if.sv
// Single-port memory bus: valid/ready request, 1-cycle read data.
// The arbiter is the master, the memory is the slave.
interface nerv_mem_if;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wstrb,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wstrb,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/nerv_mem_arbiter.sv
// Serialises each nerv core step into an optional data access
// followed by the instruction fetch on one shared memory port.
module nerv_mem_arbiter
  import nerv_mem_pkg::*;
#(
  parameter logic [31:0] RESET_INSN = NERV_NOP
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ext_stall,
  output logic        core_stall,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  nerv_mem_if.master  mem
);

  state_t      state;
  mreq_t       dreq;
  logic [31:0] iaddr;
  logic        rd_cap;
  logic        accept;

  assign accept = mem.mem_valid && mem.mem_ready;

  assign core_stall = (state != IDLE) || ext_stall;

  assign mem.mem_valid = !reset &&
    ((state == DREQ) || (state == IREQ));

  assign mem.mem_addr  = (state == DREQ) ? dreq.addr : iaddr;
  assign mem.mem_wstrb = (state == DREQ) ? dreq.wstrb : 4'h0;
  assign mem.mem_wdata = (state == DREQ) ? dreq.wdata : 32'h0;

  // rd_cap marks the single cycle where load data sits on mem_rdata
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      imem_data  <= RESET_INSN;
      dmem_rdata <= 32'h0;
      rd_cap     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!ext_stall) begin
            iaddr <= imem_addr;
            dreq  <= '{addr:  dmem_addr,
                       wstrb: dmem_wstrb,
                       wdata: dmem_wdata};
            state <= dmem_valid ? DREQ : IREQ;
          end
        end
        DREQ: begin
          if (accept) begin
            rd_cap <= (dreq.wstrb == 4'h0);
            state  <= IREQ;
          end
        end
        IREQ: begin
          if (rd_cap) dmem_rdata <= mem.mem_rdata;
          rd_cap <= 1'b0;
          if (accept) state <= IRSP;
        end
        IRSP: begin
          imem_data <= mem.mem_rdata;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nerv_mem_arbiter.sv
// Randomised bench for nerv_mem_arbiter against a step-level model
// of the core view and a bus-order scoreboard.
module tb_nerv_mem_arbiter;
  import nerv_mem_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } acc_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ext_stall = 1'b0;
  logic        core_stall;
  logic [31:0] imem_addr = 32'h0;
  logic [31:0] imem_data;
  logic        dmem_valid = 1'b0;
  logic [31:0] dmem_addr = 32'h0;
  logic [3:0]  dmem_wstrb = 4'h0;
  logic [31:0] dmem_wdata = 32'h0;
  logic [31:0] dmem_rdata;

  nerv_mem_if mem();

  nerv_mem_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .ext_stall  (ext_stall),
    .core_stall (core_stall),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_valid (dmem_valid),
    .dmem_addr  (dmem_addr),
    .dmem_wstrb (dmem_wstrb),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .mem        (mem)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] smem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];
  acc_t        expq [$];

  logic        pending = 1'b0;
  int          k, acc, waits;
  logic [31:0] exp_i = 32'h13;
  logic [31:0] exp_d = 32'h0;
  logic [31:0] nxt_i, nxt_d;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_addr;
  logic        hold_prev = 1'b0;
  acc_t        prev;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9e37_79b9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o,
      logic [3:0] s, logic [31:0] d);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] srd(logic [31:0] a);
    return smem.exists(a) ? smem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rrd(logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  task automatic tick_begin();
    @(posedge clock);
    #1;
    mem.mem_rdata = rd_pend ? srd(rd_addr) : $urandom;
    rd_pend = 1'b0;
  endtask

  task automatic rand_core();
    imem_addr  = 32'($urandom_range(0, 63)) << 2;
    dmem_addr  = 32'($urandom_range(0, 63)) << 2;
    dmem_valid = 1'($urandom_range(0, 1));
    dmem_wstrb = ($urandom_range(0, 1) == 1) ?
                 4'($urandom) : 4'h0;
    dmem_wdata = $urandom;
  endtask

  task automatic tick_end();
    acc_t e;
    #1;
    if (reset) begin
      chk("rst_valid", 32'(mem.mem_valid), 0);
      pending = 1'b0;
      expq.delete();
      exp_i = 32'h13;
      exp_d = 32'h0;
      rd_pend = 1'b0;
      hold_prev = 1'b0;
      return;
    end
    if (hold_prev) begin
      chk("hold_valid", 32'(mem.mem_valid), 1);
      chk("hold_addr", mem.mem_addr, prev.addr);
      chk("hold_wstrb", 32'(mem.mem_wstrb), 32'(prev.wstrb));
      chk("hold_wdata", mem.mem_wdata, prev.wdata);
    end
    if (mem.mem_valid) begin
      if (mem.mem_ready) begin
        if (expq.size() == 0) begin
          chk("bus_extra", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("bus_addr", mem.mem_addr, e.addr);
          chk("bus_wstrb", 32'(mem.mem_wstrb), 32'(e.wstrb));
          chk("bus_wdata", mem.mem_wdata, e.wdata);
        end
        if (mem.mem_wstrb == 4'h0) begin
          rd_pend = 1'b1;
          rd_addr = mem.mem_addr;
        end else begin
          smem[mem.mem_addr] = merge(srd(mem.mem_addr),
                                     mem.mem_wstrb,
                                     mem.mem_wdata);
        end
      end else begin
        waits++;
      end
    end
    hold_prev = mem.mem_valid && !mem.mem_ready;
    prev = '{mem.mem_addr, mem.mem_wstrb, mem.mem_wdata};
    if (pending) begin
      k++;
      if (k < acc + waits + 2) begin
        chk("busy_stall", 32'(core_stall), 1);
      end else begin
        chk("q_empty", 32'(expq.size()), 0);
        expq.delete();
        exp_i = nxt_i;
        exp_d = nxt_d;
        pending = 1'b0;
      end
    end
    if (!pending) begin
      chk("idle_stall", 32'(core_stall), 32'(ext_stall));
      chk("idle_valid", 32'(mem.mem_valid), 0);
      chk("imem_data", imem_data, exp_i);
      chk("dmem_rdata", dmem_rdata, exp_d);
      if (!ext_stall) begin
        pending = 1'b1;
        k = 0;
        waits = 0;
        acc = dmem_valid ? 2 : 1;
        if (dmem_valid) begin
          expq.push_back('{dmem_addr, dmem_wstrb, dmem_wdata});
          if (dmem_wstrb != 4'h0)
            rmem[dmem_addr] = merge(rrd(dmem_addr),
                                    dmem_wstrb, dmem_wdata);
        end
        expq.push_back('{imem_addr, 4'h0, 32'h0});
        nxt_d = (dmem_valid && dmem_wstrb == 4'h0) ?
                rrd(dmem_addr) : exp_d;
        nxt_i = rrd(imem_addr);
      end
    end
  endtask

  task automatic finish_step();
    int guard = 0;
    while (pending && guard < 40) begin
      tick_begin();
      rand_core();
      ext_stall = 1'b1;
      mem.mem_ready = 1'b1;
      tick_end();
      guard++;
    end
    if (pending) begin
      chk("timeout", 1, 0);
      pending = 1'b0;
    end
  endtask

  task automatic run_step(logic [31:0] ia, logic dv,
      logic [31:0] da, logic [3:0] ws, logic [31:0] wd,
      int nlow);
    int lows = nlow;
    int guard = 0;
    tick_begin();
    reset = 1'b0;
    ext_stall = 1'b0;
    imem_addr = ia;
    dmem_valid = dv;
    dmem_addr = da;
    dmem_wstrb = ws;
    dmem_wdata = wd;
    mem.mem_ready = 1'b1;
    tick_end();
    while (pending && guard < 40) begin
      tick_begin();
      rand_core();
      ext_stall = 1'b1;
      mem.mem_ready = (lows == 0);
      if (lows > 0) lows--;
      tick_end();
      guard++;
    end
    if (pending) begin
      chk("timeout", 1, 0);
      pending = 1'b0;
    end
  endtask

  initial begin
    mem.mem_ready = 1'b0;
    mem.mem_rdata = 32'h0;
    smem[32'h100] = 32'hDEAD_BEEF;
    rmem[32'h100] = 32'hDEAD_BEEF;
    smem[32'h200] = 32'h1122_3344;
    rmem[32'h200] = 32'h1122_3344;

    repeat (2) begin
      tick_begin();
      reset = 1'b1;
      tick_end();
    end

    run_step(32'h100, 1'b0, 32'h0, 4'h0, 32'h0, 0);
    run_step(32'h104, 1'b1, 32'h200, 4'h0, 32'h0, 0);
    run_step(32'h108, 1'b1, 32'h300, 4'hC,
             32'hAABB_0000, 0);
    run_step(32'h10C, 1'b1, 32'h300, 4'h0, 32'h0, 3);
    run_step(32'h300, 1'b1, 32'h300, 4'h3,
             32'h0000_5566, 3);

    repeat (2) begin
      tick_begin();
      rand_core();
      ext_stall = 1'b1;
      mem.mem_ready = 1'b1;
      tick_end();
    end
    run_step(32'h110, 1'b0, 32'h0, 4'h0, 32'h0, 1);

    tick_begin();
    ext_stall = 1'b0;
    imem_addr = 32'h40;
    dmem_valid = 1'b1;
    dmem_addr = 32'h80;
    dmem_wstrb = 4'h0;
    mem.mem_ready = 1'b0;
    tick_end();
    tick_begin();
    ext_stall = 1'b1;
    mem.mem_ready = 1'b0;
    tick_end();
    tick_begin();
    reset = 1'b1;
    mem.mem_ready = 1'b1;
    tick_end();
    repeat (3) begin
      tick_begin();
      reset = 1'b0;
      ext_stall = 1'b1;
      rand_core();
      mem.mem_ready = 1'b1;
      tick_end();
    end

    repeat (600) begin
      tick_begin();
      rand_core();
      ext_stall = ($urandom_range(0, 3) == 0);
      mem.mem_ready = ($urandom_range(0, 3) != 0);
      tick_end();
    end
    finish_step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
